// File: rtl/bit_serial_alu.sv
// bit_serial_alu
//   Bit-serial add / subtract / accumulate unit. One bit pair is consumed per
//   clock, LSB first. A WIDTH-bit operation therefore occupies WIDTH cycles in
//   RUN, followed by one DONE cycle that carries the completion pulse.
//
// Ports
//   clk       : sole clock; all state changes on its rising edge
//   rst       : asynchronous active-high reset
//   start     : launch request, honoured only in IDLE or DONE
//   mode      : 00 ADD, 01 SUB, 10 ACC (sum + a), 11 behaves as ADD
//   a, b      : operands (b is ignored in ACC)
//   busy      : high while bits are being processed
//   done      : one-cycle completion pulse
//   sum       : last completed result, which is also the accumulator
//   carry     : carry-out of the last result (SUB: 1 = no borrow)
//   overflow  : signed two's-complement overflow of the last result
module bit_serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_x;        // operand A shift register
    logic [WIDTH-1:0] r_y;        // operand B (or accumulator) shift register
    logic [WIDTH-2:0] r_res;      // low result bits collected so far
    logic             r_c;        // running carry between bit slices
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_x;
    logic             w_y;
    logic             w_s;
    logic             w_cout;
    logic [WIDTH-1:0] w_res_next;

    assign w_accept = start && (r_state == IDLE || r_state == DONE);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // One full-adder slice. Subtraction inverts B on the fly; the +1 comes
    // from the carry flop being preloaded with 1 at launch.
    assign w_x        = r_x[0];
    assign w_y        = r_y[0] ^ (r_mode == MODE_SUB);
    assign w_s        = w_x ^ w_y ^ r_c;
    assign w_cout     = (w_x & w_y) | (r_c & (w_x ^ w_y));
    // New bit enters at the MSB; the top WIDTH-1 bits become the new r_res,
    // and on the final slice this whole vector is the completed result.
    assign w_res_next = {w_s, r_res};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and status outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = w_accept ? RUN : IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode  <= 2'b00;
            r_x     <= '0;
            r_y     <= '0;
            r_res   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mode <= mode;
                r_x    <= a;
                // ACC feeds the current result back as the second operand;
                // in DONE this is the result completed on the previous edge.
                r_y    <= (mode == MODE_ACC) ? r_sum : b;
                r_c    <= (mode == MODE_SUB);
                r_cnt  <= '0;
            end else if (r_state == RUN) begin
                r_x   <= r_x >> 1;
                r_y   <= r_y >> 1;
                r_res <= w_res_next[WIDTH-1:1];
                r_c   <= w_cout;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_sum   <= w_res_next;
                    r_carry <= w_cout;
                    // r_c is the carry into the MSB slice at this point.
                    r_ovf   <= r_c ^ w_cout;
                end
            end
        end
    end

    assign sum      = r_sum;
    assign carry    = r_carry;
    assign overflow = r_ovf;

endmodule
